image_size_up: RTL and testbench

IMAGE_SIZE_UP -- requirements
Module: image_size_up

---
 rtl/image_pkg.sv | 13 +
 rtl/line_ram.sv | 26 ++
 rtl/image_size_up.sv | 166 ++++++++++++++++
 tb/tb_image_size_up.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and defaults for the 2x nearest-neighbour upscaler.
package image_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MAX_W_DEF  = 2048;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PASS   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one read port with a registered read.
module line_ram
  import image_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = MAX_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only updates on re, so a prefetched word stays put until consumed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/image_size_up.sv
// 2x nearest-neighbour upscaler: each pixel is emitted twice per line, each line is
// passed through once and then replayed once from the line buffer.
module image_size_up
  import image_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_W  = MAX_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       width_i,
  input  logic [15:0]       height_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tvalid_i,
  output logic              tready_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic              tlast_o,
  output logic              tuser_o
);

  localparam int ADDR_W = $clog2(MAX_W);
  localparam int OUT_W  = ADDR_W + 2;

  state_t state, next_state;

  logic [15:0]       width_q, height_q;
  logic [ADDR_W-1:0] in_x, rd_x;
  logic [OUT_W-1:0]  out_x;
  logic [15:0]       in_y;
  logic              phase, pix_valid, in_done, rd_done, pf_valid;
  logic [DATA_W-1:0] pix_data, rd_data;

  logic cfg_ok, slot_free, in_fire, out_fire, rep_load, rd_en;
  logic in_last, rd_last, out_last, y_last;

  assign cfg_ok    = (width_i != 16'd0) && (height_i != 16'd0) &&
                     ({1'b0, width_i} <= 17'(MAX_W));
  assign slot_free = !pix_valid || (phase && tready_i);
  assign in_fire   = tvalid_i && tready_o;
  assign out_fire  = pix_valid && tready_i;
  assign in_last   = {{(16-ADDR_W){1'b0}}, in_x} == (width_q - 16'd1);
  assign rd_last   = {{(16-ADDR_W){1'b0}}, rd_x} == (width_q - 16'd1);
  assign out_last  = {{(17-OUT_W){1'b0}}, out_x} == ({width_q, 1'b0} - 17'd1);
  assign y_last    = in_y == (height_q - 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // The first replay word is fetched on the final pass transfer so the repeat line
  // starts after a single bubble.
  always_comb begin
    next_state = state;
    tready_o   = 1'b0;
    rd_en      = 1'b0;
    rep_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_ok) next_state = S_PASS;
      end
      S_PASS: begin
        tready_o = !in_done && slot_free;
        if (out_fire && out_last) begin
          next_state = S_REPEAT;
          rd_en      = 1'b1;
        end
      end
      S_REPEAT: begin
        rep_load = pf_valid && slot_free;
        rd_en    = !rd_done && (!pf_valid || rep_load);
        if (out_fire && out_last) next_state = y_last ? S_IDLE : S_PASS;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_q   <= '0;
      height_q  <= '0;
      in_x      <= '0;
      rd_x      <= '0;
      out_x     <= '0;
      in_y      <= '0;
      phase     <= 1'b0;
      pix_valid <= 1'b0;
      in_done   <= 1'b0;
      rd_done   <= 1'b0;
      pf_valid  <= 1'b0;
      pix_data  <= '0;
    end else if (state == S_IDLE) begin
      width_q   <= width_i;
      height_q  <= height_i;
      in_x      <= '0;
      rd_x      <= '0;
      out_x     <= '0;
      in_y      <= '0;
      phase     <= 1'b0;
      pix_valid <= 1'b0;
      in_done   <= 1'b0;
      rd_done   <= 1'b0;
      pf_valid  <= 1'b0;
    end else begin
      if (in_fire || rep_load) begin
        pix_data  <= (state == S_PASS) ? tdata_i : rd_data;
        pix_valid <= 1'b1;
        phase     <= 1'b0;
      end else if (out_fire) begin
        if (phase) pix_valid <= 1'b0;
        phase <= !phase;
      end

      if (in_fire) begin
        if (in_last) begin
          in_x    <= '0;
          in_done <= 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end

      if (rd_en) begin
        if (rd_last) begin
          rd_x    <= '0;
          rd_done <= 1'b1;
        end else begin
          rd_x <= rd_x + 1'b1;
        end
      end

      if (rd_en)         pf_valid <= 1'b1;
      else if (rep_load) pf_valid <= 1'b0;

      if (out_fire) out_x <= out_last ? '0 : out_x + 1'b1;

      if ((state == S_REPEAT) && out_fire && out_last) begin
        in_done <= 1'b0;
        rd_done <= 1'b0;
        in_y    <= y_last ? 16'd0 : in_y + 16'd1;
      end
    end
  end

  line_ram #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_W),
    .ADDR_W(ADDR_W)
  ) u_line_ram (
    .clk  (clk),
    .we   (in_fire),
    .waddr(in_x),
    .wdata(tdata_i),
    .re   (rd_en),
    .raddr(rd_x),
    .rdata(rd_data)
  );

  assign tdata_o  = pix_data;
  assign tvalid_o = pix_valid;
  assign tlast_o  = pix_valid && out_last;
  assign tuser_o  = pix_valid && (state == S_PASS) && (in_y == 16'd0) && (out_x == '0);

endmodule

// File: tb/tb_image_size_up.sv
// Randomised bench for image_size_up against a frame-level model of the 2x upscale.
module tb_image_size_up;

  localparam int DW = 16;
  localparam int MW = 2048;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk, rstn;
  logic [15:0]   width_i, height_i;
  logic [DW-1:0] tdata_i;
  logic          tvalid_i, tready_o;
  logic [DW-1:0] tdata_o;
  logic          tvalid_o, tready_i, tlast_o, tuser_o;

  int      total = 0;
  int      bad = 0;
  int      stall_bad = 0;
  bit      rand_ready = 0;
  bit      hold_pend = 0;
  beat_t   held;
  beat_t   got_q[$];
  beat_t   exp_q[$];
  logic [DW-1:0] in_pix[$];

  image_size_up dut (
    .clk     (clk),
    .rstn    (rstn),
    .width_i (width_i),
    .height_i(height_i),
    .tdata_i (tdata_i),
    .tvalid_i(tvalid_i),
    .tready_o(tready_o),
    .tdata_o (tdata_o),
    .tvalid_o(tvalid_o),
    .tready_i(tready_i),
    .tlast_o (tlast_o),
    .tuser_o (tuser_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output recorder; also flags any change of a stalled beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && (!tvalid_o || ({tdata_o, tlast_o, tuser_o} != held))) stall_bad++;
        if (tvalid_o && tready_i) got_q.push_back({tdata_o, tlast_o, tuser_o});
        hold_pend = tvalid_o && !tready_i;
        held = {tdata_o, tlast_o, tuser_o};
      end
    end
  end

  task automatic do_reset(input int w, input int h);
    rstn     = 1'b0;
    tvalid_i = 1'b0;
    tdata_i  = '0;
    width_i  = 16'(w);
    height_i = 16'(h);
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    stall_bad = 0;
    rstn = 1'b1;
  endtask

  task automatic gen_pixels(input int n, input bit rnd);
    in_pix.delete();
    for (int i = 0; i < n; i++) in_pix.push_back(rnd ? DW'($urandom) : DW'(i + 1));
  endtask

  task automatic build_expected(input int w, input int h, input int base);
    beat_t b;
    for (int y = 0; y < h; y++)
      for (int r = 0; r < 2; r++)
        for (int x = 0; x < w; x++)
          for (int p = 0; p < 2; p++) begin
            b.data = in_pix[base + y * w + x];
            b.last = (x == w - 1) && (p == 1);
            b.user = (y == 0) && (r == 0) && (x == 0) && (p == 0);
            exp_q.push_back(b);
          end
  endtask

  task automatic send_frame(input bit gaps, input int change_at, output bit ok);
    int  cyc;
    bit  acc;
    ok = 1'b1;
    foreach (in_pix[i]) begin
      if (i == change_at) begin
        width_i  = 16'd9;
        height_i = 16'd5;
      end
      if (i == change_at + 4) begin
        width_i  = 16'd4;
        height_i = 16'd2;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tvalid_i = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      tvalid_i = 1'b1;
      tdata_i  = in_pix[i];
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 5000) begin
        @(negedge clk);
        acc = tready_o;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
    tvalid_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < n * 4 + 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2;
    rstn = 1'b0;
    #2;
    total++; if (tready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tready got=%b want=0", tready_o); end
    total++; if (tvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%b want=0", tvalid_o); end
    total++; if (tlast_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast got=%b want=0", tlast_o); end
    total++; if (tuser_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tuser got=%b want=0", tuser_o); end
    total++; if (tdata_o !== '0) begin bad++; $display("[TB] FAIL reset_tdata got=%h want=0", tdata_o); end
  endtask

  task automatic test_latency();
    int cyc = 0;
    do_reset(4, 2);
    tvalid_i = 1'b1;
    tdata_i  = 16'h00ab;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tready_o && cyc < 20);
    total++; if (tready_o !== 1'b1) begin bad++; $display("[TB] FAIL latency_ready got=%b want=1", tready_o); end
    total++; if (tvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL latency_pre_valid got=%b want=0", tvalid_o); end
    @(posedge clk);
    #1;
    tvalid_i = 1'b0;
    @(negedge clk);
    total++; if (tvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL latency_valid got=%b want=1", tvalid_o); end
    total++; if (tdata_o !== 16'h00ab) begin bad++; $display("[TB] FAIL latency_data got=%h want=00ab", tdata_o); end
    total++; if (tuser_o !== 1'b1) begin bad++; $display("[TB] FAIL latency_user got=%b want=1", tuser_o); end
  endtask

  task automatic test_basic(input bit rnd_rdy);
    bit ok;
    rand_ready = rnd_rdy;
    do_reset(4, 2);
    gen_pixels(8, 1'b0);
    build_expected(4, 2, 0);
    send_frame(rnd_rdy, -1, ok);
    wait_outputs(exp_q.size());
    total++; if (!ok) begin bad++; $display("[TB] FAIL basic_send_timeout rdy=%0d got=0 want=1", rnd_rdy); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL basic_count rdy=%0d got=%0d want=%0d", rnd_rdy, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL basic_beat[%0d] rdy=%0d got=%h/%b/%b want=%h/%b/%b", i, rnd_rdy,
                 got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL basic_stall_hold rdy=%0d got=%0d want=0", rnd_rdy, stall_bad); end
    rand_ready = 1'b0;
  endtask

  task automatic test_bad_config(input int w);
    int viol = 0;
    do_reset(w, 2);
    tvalid_i = 1'b1;
    tdata_i  = 16'h1234;
    repeat (100) begin
      @(negedge clk);
      if (tready_o || tvalid_o) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("[TB] FAIL bad_config w=%0d got=%0d want=0", w, viol); end
    @(posedge clk);
    #1;
    tvalid_i = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset(4, 2);
    gen_pixels(3, 1'b0);
    send_frame(1'b0, -1, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL midrst_send_timeout got=0 want=1"); end
    rstn = 1'b0;
    #1;
    total++; if ({tready_o, tvalid_o, tlast_o, tuser_o} !== 4'b0) begin bad++; $display("[TB] FAIL midrst_ctrl got=%b want=0000", {tready_o, tvalid_o, tlast_o, tuser_o}); end
    total++; if (tdata_o !== '0) begin bad++; $display("[TB] FAIL midrst_data got=%h want=0", tdata_o); end
    do_reset(4, 2);
    gen_pixels(8, 1'b0);
    build_expected(4, 2, 0);
    send_frame(1'b0, -1, ok);
    wait_outputs(exp_q.size());
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL midrst_beat[%0d] got=%h/%b/%b want=%h/%b/%b", i,
                 got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rand_ready = 1'b1;
    do_reset(4, 2);
    gen_pixels(16, 1'b1);
    build_expected(4, 2, 0);
    build_expected(4, 2, 8);
    send_frame(1'b0, 2, ok);
    wait_outputs(exp_q.size());
    total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_send_timeout got=0 want=1"); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL b2b_beat[%0d] got=%h/%b/%b want=%h/%b/%b", i,
                 got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL b2b_stall_hold got=%0d want=0", stall_bad); end
    rand_ready = 1'b0;
  endtask

  task automatic test_random_frames();
    int ws[4] = '{1, 3, 37, MW};
    int hs[4] = '{3, 1, 3, 1};
    bit ok;
    int n_last, n_user;
    for (int k = 0; k < 4; k++) begin
      rand_ready = (ws[k] != MW);
      do_reset(ws[k], hs[k]);
      gen_pixels(ws[k] * hs[k], 1'b1);
      build_expected(ws[k], hs[k], 0);
      send_frame(ws[k] != MW, -1, ok);
      wait_outputs(exp_q.size());
      total++; if (!ok) begin bad++; $display("[TB] FAIL rnd_send_timeout w=%0d got=0 want=1", ws[k]); end
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rnd_count w=%0d got=%0d want=%0d", ws[k], got_q.size(), exp_q.size()); end
      n_last = 0;
      n_user = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_last += int'(got_q[i].last);
        n_user += int'(got_q[i].user);
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL rnd_beat[%0d] w=%0d got=%h/%b/%b want=%h/%b/%b", i, ws[k],
                   got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
        end
      end
      total++; if (n_last !== 2 * hs[k]) begin bad++; $display("[TB] FAIL rnd_tlast_count w=%0d got=%0d want=%0d", ws[k], n_last, 2 * hs[k]); end
      total++; if (n_user !== 1) begin bad++; $display("[TB] FAIL rnd_tuser_count w=%0d got=%0d want=1", ws[k], n_user); end
      total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL rnd_stall_hold w=%0d got=%0d want=0", ws[k], stall_bad); end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    rstn     = 1'b1;
    tvalid_i = 1'b0;
    tdata_i  = '0;
    width_i  = 16'd4;
    height_i = 16'd2;
    test_reset();
    test_latency();
    test_basic(1'b0);
    test_basic(1'b1);
    test_bad_config(0);
    test_bad_config(MW + 1);
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
